// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (I)
// and load/store (D). One transaction in flight at a time: IDLE arbitrates
// and latches a request, REQ offers it to memory, RSP waits for the reply and
// routes it back to the port that owns the transaction.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req_valid/ready, if_addr    fetch request handshake
//   if_rsp_valid, if_rsp_data      fetch response (one-cycle pulse, data held)
//   d_req_valid/ready, d_addr,
//   d_we, d_wdata, d_wstrb         load/store request handshake
//   d_rsp_valid, d_rsp_data        load/store response (data 0 for stores)
//   mem_req_valid/ready, mem_addr,
//   mem_we, mem_wdata, mem_wstrb   request to memory (fields held while waiting)
//   mem_rsp_valid, mem_rsp_data    memory response
//   busy                           transaction in progress (REQ or RSP)
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_we,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic                    busy
);
    localparam int STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int STREAK_WIDTH = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_BURST);
    localparam logic [STREAK_WIDTH-1:0] STREAK_ONE = STREAK_WIDTH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    owner_d_r;     // 1: D owns the transaction, 0: I
    logic [STREAK_WIDTH-1:0] streak_r;      // D grants in a row while I waited
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    we_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_WIDTH-1:0]   wstrb_r;
    logic                    if_rsp_valid_r;
    logic [DATA_WIDTH-1:0]   if_rsp_data_r;
    logic                    d_rsp_valid_r;
    logic [DATA_WIDTH-1:0]   d_rsp_data_r;
    logic                    mem_req_valid_r;
    logic                    busy_r;
    logic                    grant_d_s;
    logic                    grant_i_s;

    // Arbitration: D wins unless I has waited through a full D streak.
    // Held off during reset so no request is acknowledged while rst is high.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (d_req_valid && !(if_req_valid && (streak_r == STREAK_MAX))) begin
                grant_d_s = 1'b1;
            end else if (if_req_valid) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> REQ -> RSP transaction sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_d_s || grant_i_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next_s = ST_RSP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RSP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus status flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            mem_req_valid_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            mem_req_valid_r <= (state_next_s == ST_REQ);
            busy_r          <= (state_next_s != ST_IDLE);
        end
    end

    // Latch the granted request; fields then stay put until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d_r <= 1'b0;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            we_r      <= 1'b0;
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {STRB_WIDTH{1'b0}};
        end else if (grant_d_s) begin
            owner_d_r <= 1'b1;
            addr_r    <= d_addr;
            we_r      <= d_we;
            wdata_r   <= d_wdata;
            wstrb_r   <= d_wstrb;
        end else if (grant_i_s) begin
            owner_d_r <= 1'b0;
            addr_r    <= if_addr;
            we_r      <= 1'b0;
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {STRB_WIDTH{1'b0}};
        end
    end

    // Streak counter: counts D grants that made a waiting I wait longer.
    // Cannot overflow: at STREAK_MAX with I waiting, D is never granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= {STREAK_WIDTH{1'b0}};
        end else if (grant_d_s) begin
            streak_r <= if_req_valid ? (streak_r + STREAK_ONE) : {STREAK_WIDTH{1'b0}};
        end else if (grant_i_s) begin
            streak_r <= {STREAK_WIDTH{1'b0}};
        end
    end

    // Route the memory reply to the owner as a one-cycle pulse; data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= {DATA_WIDTH{1'b0}};
            d_rsp_valid_r  <= 1'b0;
            d_rsp_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            if_rsp_valid_r <= 1'b0;
            d_rsp_valid_r  <= 1'b0;
            if ((state_r == ST_RSP) && mem_rsp_valid) begin
                if (owner_d_r) begin
                    d_rsp_valid_r <= 1'b1;
                    d_rsp_data_r  <= we_r ? {DATA_WIDTH{1'b0}} : mem_rsp_data;
                end else begin
                    if_rsp_valid_r <= 1'b1;
                    if_rsp_data_r  <= mem_rsp_data;
                end
            end
        end
    end

    assign if_req_ready  = grant_i_s;
    assign d_req_ready   = grant_d_s;
    assign if_rsp_valid  = if_rsp_valid_r;
    assign if_rsp_data   = if_rsp_data_r;
    assign d_rsp_valid   = d_rsp_valid_r;
    assign d_rsp_data    = d_rsp_data_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_addr      = addr_r;
    assign mem_we        = we_r;
    assign mem_wdata     = wdata_r;
    assign mem_wstrb     = wstrb_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level model (phase of
// the single outstanding transaction, D-streak count, expected response
// pulses) plus a bench-side memory with random latency/backpressure predicts
// every cycle's readies, status and responses.
module tb_mem_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_addr = 32'h0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready;
    logic [31:0] d_addr = 32'h0;
    logic        d_we = 1'b0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side memory contents, keyed by word address
    logic [31:0] mem_q [logic [31:0]];

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t        cur;
    int          phase = 0;       // 0 none, 1 offered to memory, 2 awaiting reply
    int          streak = 0;
    bit          known = 1'b0;
    bit          exp_if_v = 1'b0, exp_d_v = 1'b0;
    logic [31:0] exp_if_data = 32'h0, exp_d_data = 32'h0;
    byte         grant_log[$];
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_data = 32'h0;
    int          rsp_delay_max = 0;
    int          rdy_pct = 100;
    int          spur_pct = 0;
    bit          force_spur = 1'b0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] key;
        key = {a[31:2], 2'b00};
        if (mem_q.exists(key)) return mem_q[key];
        else return key ^ 32'hA5A5_0000;
    endfunction

    // One clock cycle: drive memory side, check outputs, advance the model.
    task automatic tick();
        bit gi, gd, rspv;
        logic [31:0] w;
        if (m_pend && m_cnt == 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = m_data;
        end else if (!m_pend && (force_spur || $urandom_range(99) < spur_pct)) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
        end else begin
            mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        end
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        gd = !rst && phase == 0 && d_req_valid && !(if_req_valid && streak == MAXB);
        gi = !rst && phase == 0 && !gd && if_req_valid;
        #1;
        n_checks++; if (if_req_ready !== gi) begin n_fail++; $display("FAIL if_req_ready: got %b want %b t=%0t", if_req_ready, gi, $time); end
        n_checks++; if (d_req_ready !== gd) begin n_fail++; $display("FAIL d_req_ready: got %b want %b t=%0t", d_req_ready, gd, $time); end
        if (known) begin
            n_checks++; if (busy !== (phase != 0)) begin n_fail++; $display("FAIL busy: got %b want %b t=%0t", busy, phase != 0, $time); end
            n_checks++; if (mem_req_valid !== (phase == 1)) begin n_fail++; $display("FAIL mem_req_valid: got %b want %b t=%0t", mem_req_valid, phase == 1, $time); end
            n_checks++; if (if_rsp_valid !== exp_if_v) begin n_fail++; $display("FAIL if_rsp_valid: got %b want %b t=%0t", if_rsp_valid, exp_if_v, $time); end
            n_checks++; if (d_rsp_valid !== exp_d_v) begin n_fail++; $display("FAIL d_rsp_valid: got %b want %b t=%0t", d_rsp_valid, exp_d_v, $time); end
            n_checks++; if (if_rsp_data !== exp_if_data) begin n_fail++; $display("FAIL if_rsp_data: got %h want %h t=%0t", if_rsp_data, exp_if_data, $time); end
            n_checks++; if (d_rsp_data !== exp_d_data) begin n_fail++; $display("FAIL d_rsp_data: got %h want %h t=%0t", d_rsp_data, exp_d_data, $time); end
            if (phase == 1) begin
                n_checks++;
                if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wstrb !== cur.wstrb ||
                    (cur.is_d && mem_wdata !== cur.wdata)) begin
                    n_fail++;
                    $display("FAIL mem_fields: got %h/%b/%h/%h want %h/%b/%h/%h t=%0t",
                             mem_addr, mem_we, mem_wstrb, mem_wdata, cur.addr, cur.we, cur.wstrb, cur.wdata, $time);
                end
            end
        end
        rspv = mem_rsp_valid;
        if (rst) begin
            known = 1'b1; phase = 0; streak = 0; m_pend = 1'b0;
            exp_if_v = 1'b0; exp_d_v = 1'b0; exp_if_data = 32'h0; exp_d_data = 32'h0;
        end else begin
            exp_if_v = 1'b0; exp_d_v = 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) m_pend = 1'b0;
                else m_cnt--;
            end
            if (gd || gi) begin
                cur.is_d  = gd;
                cur.addr  = gd ? d_addr : if_addr;
                cur.we    = gd && d_we;
                cur.wdata = d_wdata;
                cur.wstrb = gd ? d_wstrb : 4'h0;
                grant_log.push_back(gd ? 8'h44 : 8'h49);
                streak = (gd && if_req_valid) ? streak + 1 : 0;
                phase = 1;
            end else if (phase == 1 && mem_req_ready) begin
                phase = 2; m_pend = 1'b1; m_cnt = $urandom_range(rsp_delay_max);
                if (cur.we) begin
                    w = rd_word(cur.addr);
                    for (int b = 0; b < 4; b++) if (cur.wstrb[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
                    mem_q[{cur.addr[31:2], 2'b00}] = w;
                    m_data = $urandom;
                end else begin
                    m_data = rd_word(cur.addr);
                end
            end else if (phase == 2 && rspv) begin
                phase = 0;
                if (cur.is_d) begin exp_d_v = 1'b1; exp_d_data = cur.we ? 32'h0 : mem_rsp_data; end
                else begin exp_if_v = 1'b1; exp_if_data = mem_rsp_data; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int budget = 60;
        if_req_valid = 1'b0; d_req_valid = 1'b0; rst = 1'b0;
        rdy_pct = 100; spur_pct = 0;
        while ((phase != 0 || m_pend) && budget > 0) begin tick(); budget--; end
        n_checks++; if (phase != 0) begin n_fail++; $display("FAIL drain_timeout: phase %0d want 0", phase); end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();
        rst = 1'b0; grant_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b0;
        if_addr = 32'h4; d_addr = 32'h8; rdy_pct = 100; rsp_delay_max = 0;
        tick(); tick();
        rst = 1'b0; grant_log.delete();
        tick();
        n_checks++;
        if (grant_log.size() != 1 || grant_log[0] != 8'h44) begin
            n_fail++; $display("FAIL reset_first_grant: got %0d grants want one D grant", grant_log.size());
        end
        drain();
    endtask

    task automatic test_single_fetch();
        do_reset();
        mem_q[32'h10] = 32'h00A00093;
        if_req_valid = 1'b1; if_addr = 32'h10; rdy_pct = 100; rsp_delay_max = 0;
        tick();
        if_req_valid = 1'b0;
        tick(); tick();
        #1;
        n_checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00A00093) begin
            n_fail++; $display("FAIL single_fetch_cycle3: got %b/%h want 1/00a00093", if_rsp_valid, if_rsp_data);
        end
        tick(); tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h20;
        tick();
        d_req_valid = 1'b0;
        tick(); tick(); tick();
        if_req_valid = 1'b0;
        drain();
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] != 8'h44 || grant_log[1] != 8'h49) begin
            n_fail++; $display("FAIL simultaneous_order: got %0d grants want D then I", grant_log.size());
        end
    endtask

    task automatic test_starvation();
        string exp_order;
        exp_order = "DDDDIDDDDI";
        do_reset();
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b0; rdy_pct = 100; rsp_delay_max = 0;
        repeat (30) tick();
        drain();
        n_checks++;
        if (grant_log.size() < 10) begin
            n_fail++; $display("FAIL starvation_count: got %0d grants want >= 10", grant_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (grant_log[i] != exp_order[i]) begin
                    n_fail++; $display("FAIL starvation_order[%0d]: got %c want %c", i, grant_log[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_store_backpressure();
        int req_cycles = 0;
        do_reset();
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        rdy_pct = 0; rsp_delay_max = 0;
        tick();
        d_req_valid = 1'b0; d_we = 1'b0;
        repeat (3) begin if (mem_req_valid === 1'b1) req_cycles++; tick(); end
        rdy_pct = 100;
        if (mem_req_valid === 1'b1) req_cycles++;
        tick();
        n_checks++; if (req_cycles != 4 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 4", req_cycles); end
        tick();
        #1;
        n_checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0 || if_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_rsp: got %b/%h/%b want 1/00000000/0", d_rsp_valid, d_rsp_data, if_rsp_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_rsp();
        do_reset();
        if_req_valid = 1'b1; if_addr = 32'h80; rdy_pct = 100; rsp_delay_max = 0;
        tick();
        if_req_valid = 1'b0;
        tick();
        m_cnt = 5;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        force_spur = 1'b1; tick(); force_spur = 1'b0;
        tick();
        #1;
        n_checks++;
        if (busy !== 1'b0 || if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_rsp: busy/if_v/d_v got %b/%b/%b want 0/0/0", busy, if_rsp_valid, d_rsp_valid);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        rdy_pct = 70; spur_pct = 10; rsp_delay_max = 3;
        for (int c = 0; c < 800; c++) begin
            if_req_valid = ($urandom_range(99) < 60);
            d_req_valid  = ($urandom_range(99) < 60);
            if_addr = 32'($urandom_range(15)) << 2;
            d_addr  = 32'($urandom_range(15)) << 2;
            d_we    = $urandom_range(1) == 1;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(15));
            rst     = ($urandom_range(199) == 0);
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store_backpressure();
        test_reset_mid_rsp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
